// File: rtl/sqrt_pipe_pkg.sv
// Shared constants and types for the integer square-root pipeline family.
// SQRT_INVERSE_REM_CHECK_EN adds a remainder-error bit to the stage sideband.
package sqrt_pipe_pkg;

    localparam int unsigned SqrtBits   = 8;
    localparam int unsigned SqrtStages = SqrtBits;

    function automatic int unsigned calc_rw(int unsigned bits);
        return bits + 1;
    endfunction

    function automatic int unsigned calc_ow(int unsigned bits);
        return 2 * bits;
    endfunction

`ifdef SQRT_INVERSE_REM_CHECK_EN
    typedef struct packed {
        logic valid;
        logic err;
    } sideband_t;
`else
    typedef struct packed {
        logic valid;
    } sideband_t;
`endif

endpackage

// File: rtl/sqrt_inverse_stage.sv
// One conditional shift-add stage of the inverse square-root pipeline:
// adds (root << (K-1)) to the accumulator when root bit K-1 is set.
module sqrt_inverse_stage
    import sqrt_pipe_pkg::*;
#(
    parameter int unsigned BITS = SqrtBits,
    parameter int unsigned K    = 1,
    localparam int unsigned OW  = calc_ow(BITS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [OW:0]     acc_i,
    input  logic [BITS-1:0] r_i,
    input  sideband_t       sb_i,
    output logic [OW:0]     acc_o,
    output logic [BITS-1:0] r_o,
    output sideband_t       sb_o
);

    logic [OW:0]     addend;
    logic [OW:0]     acc_d;
    logic [OW:0]     acc_q;
    logic [BITS-1:0] r_q;
    sideband_t       sb_q;

    always_comb begin
        addend = '0;
        if (r_i[K-1]) begin
            addend = {{(OW + 1 - BITS){1'b0}}, r_i} << (K - 1);
        end
        acc_d = acc_i + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            r_q   <= '0;
            sb_q  <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
            r_q   <= r_i;
            sb_q  <= sb_i;
        end
    end

    assign acc_o = acc_q;
    assign r_o   = r_q;
    assign sb_o  = sb_q;

endmodule

// File: rtl/sqrt_inverse_pipelined.sv
// Pipelined radicand reconstruction x = root*root + rem, one result per clock.
// Optional macro SQRT_INVERSE_REM_CHECK_EN flags rem > 2*root on out_rem_err_o.
module sqrt_inverse_pipelined
    import sqrt_pipe_pkg::*;
#(
    parameter int unsigned BITS = SqrtStages,
    localparam int unsigned UP  = BITS - 1,
    localparam int unsigned RW  = calc_rw(BITS),
    localparam int unsigned OW  = calc_ow(BITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          in_valid_i,
    input  logic [UP:0]   root_i,
    input  logic [RW-1:0] rem_i,
    output logic          out_valid_o,
    output logic [OW-1:0] out_x_o,
    output logic          out_ovf_o,
    output logic          out_rem_err_o
);

    logic [OW:0] acc0_q;
    logic [UP:0] r0_q;
    sideband_t   sb0_d;
    sideband_t   sb0_q;

    // Index 0 is the capture stage, index k the output of shift-add stage k.
    logic [OW:0] acc_w [BITS+1];
    logic [UP:0] r_w   [BITS+1];
    sideband_t   sb_w  [BITS+1];

    always_comb begin
        sb0_d       = '0;
        sb0_d.valid = in_valid_i;
`ifdef SQRT_INVERSE_REM_CHECK_EN
        sb0_d.err   = {1'b0, rem_i} > {1'b0, root_i, 1'b0};
`endif
    end

    // Operands are captured every enabled cycle; only the valid bit qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0_q <= '0;
            r0_q   <= '0;
            sb0_q  <= '0;
        end else if (en_i) begin
            acc0_q <= {{(OW + 1 - RW){1'b0}}, rem_i};
            r0_q   <= root_i;
            sb0_q  <= sb0_d;
        end
    end

    assign acc_w[0] = acc0_q;
    assign r_w[0]   = r0_q;
    assign sb_w[0]  = sb0_q;

    for (genvar k = 1; k <= BITS; k++) begin : g_stage
        sqrt_inverse_stage #(
            .BITS (BITS),
            .K    (k)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (en_i),
            .acc_i (acc_w[k-1]),
            .r_i   (r_w[k-1]),
            .sb_i  (sb_w[k-1]),
            .acc_o (acc_w[k]),
            .r_o   (r_w[k]),
            .sb_o  (sb_w[k])
        );
    end

    assign out_valid_o = sb_w[BITS].valid;
    assign out_x_o     = acc_w[BITS][OW-1:0];
    assign out_ovf_o   = acc_w[BITS][OW];

`ifdef SQRT_INVERSE_REM_CHECK_EN
    assign out_rem_err_o = sb_w[BITS].err;
`else
    assign out_rem_err_o = 1'b0;
`endif

    // The final root copy is not needed at the output.
    logic unused_r;
    assign unused_r = ^r_w[BITS];

endmodule
